// File: rtl/echo_capture_channel.sv
// echo_capture_channel: circular-buffer sample capture with echo stop, post-stop delay and readout.
// Optional `ECHO_CAPTURE_AUTO_STOP_EN adds a threshold port that triggers the echo stop from din.
module echo_capture_channel #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DELAY_W = 8,
  parameter int TS_W    = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  din,
  input  logic               start_pulse,
  input  logic               stop_pulse,
  input  logic               stop_recording,
  input  logic [DELAY_W-1:0] stop_delay,
  input  logic [TS_W-1:0]    abs_counter,
`ifdef ECHO_CAPTURE_AUTO_STOP_EN
  input  logic [DATA_W-1:0]  threshold,
`endif
  input  logic               rd_req,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               done,
  output logic               echo_pulse_detected,
  output logic               wrapped,
  output logic               rd_empty,
  output logic [ADDR_W:0]    sample_length,
  output logic [TS_W-1:0]    timestamp
);
  typedef enum logic [1:0] {IDLE, REC, POST, DONE} state_t;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  state_t             state_q, state_d;
  logic [ADDR_W:0]    len_q, len_d, rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]  wr_q, wr_d, rd_ptr_q, rd_ptr_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               wrap_q, wrap_d, echo_q, echo_d, rd_valid_q, rd_valid_d;
  logic               we, stop_evt, recording;
  logic [DATA_W-1:0]  mem [0:(1<<ADDR_W)-1];
`ifdef ECHO_CAPTURE_AUTO_STOP_EN
  assign stop_evt = stop_pulse | (din >= threshold);
`else
  assign stop_evt = stop_pulse;
`endif
  assign recording = (state_q == REC) || (state_q == POST);
  assign rd_empty  = (state_q != DONE) || (rd_cnt_q == len_q);
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_d       = wr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    cnt_d      = cnt_q;
    ts_d       = ts_q;
    wrap_d     = wrap_q;
    echo_d     = echo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    we         = 1'b0;
    if (start_pulse) begin
      state_d  = REC;
      len_d    = '0;
      wr_d     = '0;
      rd_ptr_d = '0;
      rd_cnt_d = '0;
      wrap_d   = 1'b0;
      echo_d   = 1'b0;
    end else begin
      if (recording) begin
        we   = 1'b1;
        wr_d = wr_q + 1'b1;
        // once full, the read pointer tracks the oldest surviving sample
        if (len_q == FULL) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          wrap_d   = 1'b1;
        end else begin
          len_d = len_q + 1'b1;
        end
      end
      if (state_q == REC && stop_evt) begin
        ts_d    = abs_counter;
        echo_d  = 1'b1;
        cnt_d   = stop_delay;
        state_d = (stop_delay == '0) ? DONE : POST;
      end else if (state_q == REC && stop_recording) begin
        state_d = DONE;
      end else if (state_q == POST) begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == DELAY_W'(1)) ? DONE : POST;
      end
      if (rd_req && !rd_empty) begin
        rd_valid_d = 1'b1;
        rd_data_d  = mem[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_cnt_d   = rd_cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      wr_q       <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      cnt_q      <= '0;
      ts_q       <= '0;
      wrap_q     <= 1'b0;
      echo_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_q       <= wr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      cnt_q      <= cnt_d;
      ts_q       <= ts_d;
      wrap_q     <= wrap_d;
      echo_q     <= echo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wr_q] <= din;
  end
  assign busy                = recording;
  assign done                = state_q == DONE;
  assign echo_pulse_detected = echo_q;
  assign wrapped             = wrap_q;
  assign sample_length       = len_q;
  assign timestamp           = ts_q;
  assign rd_data             = rd_data_q;
  assign rd_valid            = rd_valid_q;
endmodule

// File: doc/echo_capture_channel.md
ECHO_CAPTURE_CHANNEL -- requirements
Module: echo_capture_channel

Interface
REQ-001 Parameter DATA_W, default 8: sample width in bits.
REQ-002 Parameter ADDR_W, default 8: buffer depth is DEPTH = 2^ADDR_W samples.
REQ-003 Parameter DELAY_W, default 8: post-stop delay counter width.
REQ-004 Parameter TS_W, default 13: timestamp width.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 din  in  DATA_W  ADC sample stream, one sample per cycle.
REQ-008 start_pulse / stop_pulse / stop_recording  in  1 each  arm; echo stop with delay; abort without echo.
REQ-009 stop_delay  in  DELAY_W  post-stop samples; abs_counter  in  TS_W  free-running timestamp.
REQ-010 rd_req  in  1  readout request; rd_data  out  DATA_W; rd_valid  out  1.
REQ-011 busy, done, echo_pulse_detected, wrapped, rd_empty  out  1 each; sample_length  out  ADDR_W+1; timestamp  out  TS_W.

Function
REQ-012 FSM states IDLE, REC, POST, DONE; busy=1 in REC/POST, done=1 in DONE.
REQ-013 start_pulse in any state: next state REC; sample_length, write pointer, read pointer, wrapped and echo_pulse_detected all cleared; timestamp held.
REQ-014 Each cycle spent in REC or POST writes din of that cycle into an internal circular RAM of DEPTH words, in order.
REQ-015 sample_length increments per write and saturates at DEPTH; further writes overwrite the oldest sample, advance the oldest pointer, and set wrapped=1.
REQ-016 stop_pulse in REC: timestamp<=abs_counter, echo_pulse_detected<=1, counter loaded with stop_delay; next state POST, or DONE if stop_delay==0.
REQ-017 POST: counter decrements once per write; after exactly stop_delay samples beyond the stop cycle, next state DONE.
REQ-018 stop_recording in REC: next state DONE; echo_pulse_detected and timestamp unchanged.
REQ-019 Precedence: start_pulse > stop_pulse > stop_recording; stop_pulse/stop_recording ignored outside REC.
REQ-020 Readout only in DONE: rd_req with unread samples gives rd_valid=1 and rd_data one cycle later, oldest first.
REQ-021 rd_empty=1 when all sample_length samples are read or state is not DONE; rd_req then ignored with rd_valid=0.
REQ-022 rd_req outside DONE has no effect; start_pulse during readout aborts it, with no rd_valid on the next cycle.

Reset
REQ-023 reset low: state IDLE; all pointers, counters and flags 0; rd_data 0; timestamp 0; RAM contents undefined.
REQ-024 reset asserted mid-REC/POST/readout takes effect immediately; after release the block stays in IDLE until start_pulse.

Configuration
REQ-025 Macro ECHO_CAPTURE_AUTO_STOP_EN defined: port threshold (in, DATA_W) exists; in REC, din>=threshold acts as stop_pulse on that cycle (same precedence).
REQ-026 Macro undefined: no threshold port and no comparator; only stop_pulse stops with echo.

Verification
REQ-027 start, 10 cycles din=0..9, stop_pulse with stop_delay=3 and abs_counter=0x123 -> 14 samples 0..13, timestamp 0x123, echo_pulse_detected=1, done=1.
REQ-028 DEPTH=256, start, 300 samples din=n mod 256, stop_delay=0 -> sample_length=256, wrapped=1, readout begins with 45 and ends with 44.
REQ-029 start, 5 samples, stop_recording -> done=1, echo_pulse_detected=0, sample_length=5, timestamp unchanged.
REQ-030 start_pulse and stop_pulse same cycle while in REC -> restart: state REC, sample_length=0, echo_pulse_detected=0.
REQ-031 DONE with 4 samples, rd_req held 6 cycles -> exactly 4 rd_valid pulses, each 1 cycle after its request, then rd_empty=1.
REQ-032 With ECHO_CAPTURE_AUTO_STOP_EN, threshold=0x80, ramp din from 0 -> stop on din=0x80 cycle, timestamp latched there, stop_delay samples follow.
